// File: rtl/instr_stream_buffer.sv
// Instruction store with an in-order valid/ready stream to decode.
// Program memory is loaded through a write port while the stream is idle.
module instr_stream_buffer #(
  parameter int  INSTR_W = 25,
  parameter int  DEPTH   = 64,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];

  state_t             state, state_d;
  logic [ADDR_W:0]    pc, pc_d;
  logic [ADDR_W:0]    len, len_d;
  logic [ADDR_W:0]    plen_clamp;
  logic               valid_d;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  opc_d;
  logic               mem_we;

  assign plen_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign mem_we     = wr_en && (state != FETCH);
  assign busy       = (state == FETCH);
  assign done       = (state == DONE);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    len_d   = len;
    valid_d = out_valid;
    instr_d = out_instr;
    opc_d   = out_pc;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      pc_d    = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_d   = plen_clamp;
            pc_d    = '0;
            state_d = (plen_clamp != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (out_valid && out_ready && pc == len) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if ((!out_valid || out_ready) && pc < len) begin
            instr_d = mem[pc[ADDR_W-1:0]];
            opc_d   = pc[ADDR_W-1:0];
            valid_d = 1'b1;
            pc_d    = pc + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      len       <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      len       <= len_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_pc    <= opc_d;
    end
  end

  // Storage has no reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instr_stream_buffer.sv
// Bench for instr_stream_buffer: table vectors, directed corners
// and randomized runs checked against an array/queue model.
module tb_instr_stream_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [24:0] wr_data = '0;
  logic [6:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [24:0] out_instr;
  logic [5:0]  out_pc;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail = 0;

  logic [24:0] model [64];

  instr_stream_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int plen;
    int mode;
    bit wr_fetch;
    int exp_xf;
    int exp_last;
    int exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [24:0] d);
    wr_en = 1'b1;
    wr_addr = a[5:0];
    wr_data = d;
    step();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on out_pc 1
  task automatic run_prog(input int plen, input int mode, input bit wr_fetch,
                          output int xf, output int last_pc,
                          output int cyc);
    int exp_n;
    int stalls;
    bit held;
    logic [5:0] hpc;
    logic [24:0] hins;
    exp_n = (plen > 64) ? 64 : plen;
    prog_len = plen[6:0];
    start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    if (wr_fetch) begin
      wr_en = 1'b1;
      wr_addr = 6'd1;
      wr_data = 25'h1ABCDEF;
    end
    xf = 0;
    last_pc = -1;
    cyc = 0;
    stalls = 0;
    held = 1'b0;
    hpc = '0;
    hins = '0;
    while (!done && cyc < 2000) begin
      if (held) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_pc", {26'd0, out_pc}, {26'd0, hpc});
        check("hold_instr", {7'd0, out_instr}, {7'd0, hins});
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && out_pc == 6'd1 && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid && out_ready) begin
        check("xfer_pc", {26'd0, out_pc}, xf);
        check("xfer_instr", {7'd0, out_instr}, {7'd0, model[xf[5:0]]});
        last_pc = int'(out_pc);
        xf++;
      end
      held = out_valid && !out_ready;
      hpc = out_pc;
      hins = out_instr;
      step();
      cyc++;
      wr_en = 1'b0;
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("xfer_count", xf, exp_n);
    check("valid_in_done", {31'd0, out_valid}, 32'd0);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    if (mode == 2) check("stall_cycles", stalls, 3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_instr"}, {7'd0, out_instr}, 32'd0);
    check({tag, "_pc"}, {26'd0, out_pc}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t vt[6];
    int xf, lp, cyc;

    vt[0] = '{plen: 4,   mode: 0, wr_fetch: 0, exp_xf: 4,  exp_last: 3,  exp_cyc: 5};
    vt[1] = '{plen: 4,   mode: 2, wr_fetch: 0, exp_xf: 4,  exp_last: 3,  exp_cyc: 8};
    vt[2] = '{plen: 0,   mode: 0, wr_fetch: 0, exp_xf: 0,  exp_last: -1, exp_cyc: 0};
    vt[3] = '{plen: 100, mode: 0, wr_fetch: 0, exp_xf: 64, exp_last: 63, exp_cyc: 65};
    vt[4] = '{plen: 1,   mode: 0, wr_fetch: 0, exp_xf: 1,  exp_last: 0,  exp_cyc: 2};
    vt[5] = '{plen: 64,  mode: 0, wr_fetch: 1, exp_xf: 64, exp_last: 63, exp_cyc: 65};

    step();
    check_all_zero("reset");
    step();
    rst = 1'b0;

    for (int i = 0; i < 64; i++) load(i, 25'($urandom));
    for (int i = 0; i < 4; i++) load(i, 25'(i + 1));

    for (int i = 0; i < 6; i++) begin
      run_prog(vt[i].plen, vt[i].mode, vt[i].wr_fetch, xf, lp, cyc);
      check($sformatf("vec%0d_count", i), xf, vt[i].exp_xf);
      check($sformatf("vec%0d_last_pc", i), lp, vt[i].exp_last);
      check($sformatf("vec%0d_cycles", i), cyc, vt[i].exp_cyc);
    end

    // Write ignored while streaming: mem[1] must still read back as 2.
    run_prog(2, 0, 0, xf, lp, cyc);
    check("mem1_kept", {7'd0, model[1]}, 32'd2);

    // flush and start together: flush wins.
    prog_len = 7'd4;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    check("flush_start_done", {31'd0, done}, 32'd0);

    // Write in the same cycle as start: stream sees the new word.
    wr_en = 1'b1;
    wr_addr = 6'd0;
    wr_data = 25'h0155AA;
    model[0] = 25'h0155AA;
    run_prog(3, 0, 0, xf, lp, cyc);

    for (int i = 0; i < 8; i++) load(i, 25'h100 + 25'(i));

    // Flush after two transfers of an 8-word program.
    prog_len = 7'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    check("pre_flush_pc", {26'd0, out_pc}, 32'd2);
    check("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    run_prog(8, 0, 0, xf, lp, cyc);

    // Asynchronous reset mid-run, then replay from address 0.
    prog_len = 7'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    rst = 1'b0;
    run_prog(8, 1, 0, xf, lp, cyc);

    // Randomized reloads and runs, checked against the model array.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) load($urandom_range(0, 63), 25'($urandom));
      run_prog($urandom_range(0, 80), $urandom_range(0, 1), 1'($urandom),
               xf, lp, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
